// File: rtl/intr_ctrl_if.sv
// Interrupt controller <-> CPU/source signal bundle.
// The master drives interrupt lines, ack/reti and mask writes; the slave is the controller.
interface intr_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              intr1;
    logic              intr2;
    logic              ack;
    logic              reti;
    logic              mask_we;
    logic [1:0]        mask_wd;
    logic              irq;
    logic [ADDR_W-1:0] vector;
    logic [1:0]        pending;
    logic [1:0]        in_service;

    modport master (
        output intr1, intr2, ack, reti, mask_we, mask_wd,
        input  irq, vector, pending, in_service
    );

    modport slave (
        input  intr1, intr2, ack, reti, mask_we, mask_wd,
        output irq, vector, pending, in_service
    );
endinterface

// File: rtl/intr_ctrl.sv
// Two-source interrupt controller: sync + edge detect, pending/mask, fixed priority.
// Optional INTR_NESTING_EN lets intr1 preempt an in-service intr2.
module intr_ctrl #(
    parameter int                ADDR_W = 10,
    parameter logic [ADDR_W-1:0] VEC1   = 10'h3F0,
    parameter logic [ADDR_W-1:0] VEC2   = 10'h3F8
) (
    input logic        clk,
    input logic        reset,
    intr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        s1_q, s2_q, s3_q;
    logic [1:0]        pending_q, pending_d;
    logic [1:0]        in_service_q, in_service_d;
    logic [1:0]        mask_q, mask_d;
    logic              irq_q, irq_d;
    logic [ADDR_W-1:0] vector_q, vector_d;
    logic [1:0]        edge_det;
    logic [1:0]        eligible;
    logic [1:0]        clr;
    logic [1:0]        gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= 2'b00;
            s2_q         <= 2'b00;
            s3_q         <= 2'b00;
            pending_q    <= 2'b00;
            in_service_q <= 2'b00;
            mask_q       <= 2'b00;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            state_q      <= IDLE;
        end else begin
            s1_q         <= {bus.intr2, bus.intr1};
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            irq_q        <= irq_d;
            vector_q     <= vector_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        edge_det     = s2_q & ~s3_q;
        eligible     = pending_q & ~mask_q;
        mask_d       = bus.mask_we ? bus.mask_wd : mask_q;
        state_d      = state_q;
        irq_d        = irq_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        clr          = 2'b00;
        gnt          = (vector_q == VEC1) ? 2'b01 : 2'b10;

        unique case (state_q)
            IDLE: begin
                irq_d = |eligible;
                if (|eligible) begin
                    state_d  = REQ;
                    vector_d = eligible[0] ? VEC1 : VEC2;
                end
            end
            REQ: begin
                if (irq_q && bus.ack) begin
                    clr          = gnt;
                    in_service_d = in_service_q | gnt;
                    irq_d        = 1'b0;
                    state_d      = SVC;
                end else if (|eligible) begin
                    irq_d    = 1'b1;
                    vector_d = eligible[0] ? VEC1 : VEC2;
                end else begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SVC: begin
`ifdef INTR_NESTING_EN
                if (irq_q && bus.ack) begin
                    clr          = 2'b01;
                    in_service_d = in_service_q | 2'b01;
                    irq_d        = 1'b0;
                end else if (bus.reti) begin
                    // intr1 outranks intr2, so it retires first
                    in_service_d = in_service_q[0] ?
                                   {in_service_q[1], 1'b0} : 2'b00;
                    irq_d        = 1'b0;
                    if (in_service_d == 2'b00) state_d = IDLE;
                    if (in_service_d == 2'b10) vector_d = VEC2;
                end else begin
                    irq_d = !in_service_q[0] && eligible[0];
                    if (irq_d) vector_d = VEC1;
                end
`else
                irq_d = 1'b0;
                if (bus.reti) begin
                    in_service_d = 2'b00;
                    state_d      = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase

        // a fresh edge outranks the grant of the same source
        pending_d = (pending_q & ~clr) | edge_det;
    end

    assign bus.irq        = irq_q;
    assign bus.vector     = vector_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: per-cycle vector table plus reset and nesting sequences.
// Table rows apply inputs at the falling edge and check outputs 1 ns after the rising edge.
module tb_intr_ctrl;
    localparam logic [9:0] V0 = 10'h000;
    localparam logic [9:0] V1 = 10'h3F0;
    localparam logic [9:0] V2 = 10'h3F8;

    typedef struct {
        logic       i1, i2, ack, reti, mwe;
        logic [1:0] mwd;
        logic       irq;
        logic [9:0] vec;
        logic [1:0] pend, isv;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    intr_ctrl_if #(.ADDR_W(10)) bus ();

    intr_ctrl #(.ADDR_W(10), .VEC1(V1), .VEC2(V2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic irq, input logic [9:0] vec,
                           input logic [1:0] pend, input logic [1:0] isv);
        chk({nm, " irq"}, 32'(bus.irq), 32'(irq));
        chk({nm, " vector"}, 32'(bus.vector), 32'(vec));
        chk({nm, " pending"}, 32'(bus.pending), 32'(pend));
        chk({nm, " in_service"}, 32'(bus.in_service), 32'(isv));
    endtask

    task automatic step(input logic i1, input logic i2, input logic a, input logic r,
                        input logic mwe, input logic [1:0] mwd);
        @(negedge clk);
        bus.intr1   = i1;
        bus.intr2   = i2;
        bus.ack     = a;
        bus.reti    = r;
        bus.mask_we = mwe;
        bus.mask_wd = mwd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic wait_irq(input string nm, input int max);
        int n = 0;
        while (!bus.irq && n < max) begin
            idle();
            n++;
        end
        chk({nm, " irq timeout"}, 32'(bus.irq), 32'd1);
    endtask

    task automatic add(input logic i1, i2, a, r, mwe, input logic [1:0] mwd,
                       input logic irq, input logic [9:0] vec,
                       input logic [1:0] pend, input logic [1:0] isv);
        vec_t v;
        v = '{i1, i2, a, r, mwe, mwd, irq, vec, pend, isv};
        tv.push_back(v);
    endtask

    initial begin
        // intr1 alone, held until ack, then reti
        add(1,0,0,0,0,0, 0,V0,0,0); add(1,0,0,0,0,0, 0,V0,0,0);
        add(1,0,0,0,0,0, 0,V0,1,0); add(1,0,0,0,0,0, 1,V1,1,0);
        add(1,0,0,0,0,0, 1,V1,1,0); add(1,0,1,0,0,0, 0,V1,0,1);
        add(1,0,0,0,0,0, 0,V1,0,1); add(0,0,0,1,0,0, 0,V1,0,0);
        add(0,0,0,0,0,0, 0,V1,0,0); add(0,0,0,0,0,0, 0,V1,0,0);
        // simultaneous rise: intr1 first, intr2 after reti
        add(1,1,0,0,0,0, 0,V1,0,0); add(1,1,0,0,0,0, 0,V1,0,0);
        add(1,1,0,0,0,0, 0,V1,3,0); add(1,1,0,0,0,0, 1,V1,3,0);
        add(1,1,1,0,0,0, 0,V1,2,1); add(0,0,0,1,0,0, 0,V1,2,0);
        add(0,0,0,0,0,0, 1,V2,2,0); add(0,0,1,0,0,0, 0,V2,0,2);
        add(0,0,0,1,0,0, 0,V2,0,0);
        // masked intr1 stays pending, unmask releases it
        add(0,0,0,0,1,1, 0,V2,0,0); add(1,0,0,0,0,0, 0,V2,0,0);
        add(1,0,0,0,0,0, 0,V2,0,0); add(1,0,0,0,0,0, 0,V2,1,0);
        add(0,0,0,0,0,0, 0,V2,1,0); add(0,0,0,0,0,0, 0,V2,1,0);
        add(0,0,0,0,1,0, 0,V2,1,0); add(0,0,0,0,0,0, 1,V1,1,0);
        add(0,0,1,0,0,0, 0,V1,0,1); add(0,0,0,1,0,0, 0,V1,0,0);
        // intr1 overrides a waiting intr2
        add(0,1,0,0,0,0, 0,V1,0,0); add(0,1,0,0,0,0, 0,V1,0,0);
        add(0,1,0,0,0,0, 0,V1,2,0); add(1,1,0,0,0,0, 1,V2,2,0);
        add(1,0,0,0,0,0, 1,V2,2,0); add(1,0,0,0,0,0, 1,V2,3,0);
        add(1,0,0,0,0,0, 1,V1,3,0); add(0,0,1,0,0,0, 0,V1,2,1);
        add(0,0,0,1,0,0, 0,V1,2,0); add(0,0,0,0,0,0, 1,V2,2,0);
        // masking in REQ drops irq; stray ack/reti ignored; ack+reti together
        add(0,0,0,0,1,2, 1,V2,2,0); add(0,0,0,0,0,0, 0,V2,2,0);
        add(0,0,1,0,0,0, 0,V2,2,0); add(0,0,0,1,0,0, 0,V2,2,0);
        add(0,0,0,0,1,0, 0,V2,2,0); add(0,0,0,0,0,0, 1,V2,2,0);
        add(0,0,1,1,0,0, 0,V2,0,2); add(0,0,0,1,0,0, 0,V2,0,0);
        // new intr2 edge in the same cycle as its grant keeps pending set
        add(0,1,0,0,0,0, 0,V2,0,0); add(0,0,0,0,0,0, 0,V2,0,0);
        add(0,0,0,0,0,0, 0,V2,2,0); add(0,1,0,0,0,0, 1,V2,2,0);
        add(0,1,0,0,0,0, 1,V2,2,0); add(0,1,1,0,0,0, 0,V2,2,2);
        add(0,0,0,1,0,0, 0,V2,2,0); add(0,0,0,0,0,0, 1,V2,2,0);
        add(0,0,1,0,0,0, 0,V2,0,2); add(0,0,0,1,0,0, 0,V2,0,0);

        reset       = 1'b0;
        bus.intr1   = 1'b0;
        bus.intr2   = 1'b0;
        bus.ack     = 1'b0;
        bus.reti    = 1'b0;
        bus.mask_we = 1'b0;
        bus.mask_wd = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, V0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].i1, tv[i].i2, tv[i].ack, tv[i].reti, tv[i].mwe, tv[i].mwd);
            chk_all($sformatf("row%0d", i), tv[i].irq, tv[i].vec, tv[i].pend, tv[i].isv);
        end

        // async reset while servicing intr2 with everything masked
        repeat (3) step(0, 1, 0, 0, 0, 2'b00);
        wait_irq("rst pre", 4);
        chk("rst pre vector", 32'(bus.vector), 32'(V2));
        step(0, 0, 1, 0, 0, 2'b00);
        step(0, 0, 0, 0, 1, 2'b11);
        chk_all("rst svc", 0, V2, 0, 2);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst async", 0, V0, 0, 0);
        reset = 1'b1;
        step(0, 1, 0, 0, 0, 2'b00);
        step(0, 1, 0, 0, 0, 2'b00);
        step(0, 1, 0, 0, 0, 2'b00);
        chk_all("rst k+2", 0, V0, 2, 0);
        idle();
        chk_all("rst k+3", 1, V2, 2, 0);
        step(0, 0, 1, 0, 0, 2'b00);
        chk_all("rst ack", 0, V2, 0, 2);
        step(0, 0, 0, 1, 0, 2'b00);
        chk_all("rst reti", 0, V2, 0, 0);

        // intr1 arrives while intr2 is in service
        repeat (3) step(0, 1, 0, 0, 0, 2'b00);
        idle();
        chk_all("nest req2", 1, V2, 2, 0);
        step(0, 0, 1, 0, 0, 2'b00);
        chk_all("nest svc2", 0, V2, 0, 2);
        step(1, 0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 0, 2'b00);
        chk_all("nest pend1", 0, V2, 1, 2);
        idle();
`ifdef INTR_NESTING_EN
        chk_all("nest req1", 1, V1, 1, 2);
        step(0, 0, 1, 0, 0, 2'b00);
        chk_all("nest ack1", 0, V1, 0, 3);
        step(0, 0, 0, 1, 0, 2'b00);
        chk_all("nest reti1", 0, V2, 0, 2);
        idle();
        chk_all("nest hold", 0, V2, 0, 2);
        step(0, 0, 0, 1, 0, 2'b00);
        chk_all("nest reti2", 0, V2, 0, 0);
        idle();
        chk_all("nest idle", 0, V2, 0, 0);
`else
        chk_all("nest blocked", 0, V2, 1, 2);
        step(0, 0, 1, 0, 0, 2'b00);
        chk_all("nest ack ign", 0, V2, 1, 2);
        step(0, 0, 0, 1, 0, 2'b00);
        chk_all("nest reti2", 0, V2, 1, 0);
        idle();
        chk_all("nest req1", 1, V1, 1, 0);
        step(0, 0, 1, 0, 0, 2'b00);
        chk_all("nest ack1", 0, V1, 0, 1);
        step(0, 0, 0, 1, 0, 2'b00);
        chk_all("nest reti1", 0, V1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller sitting directly upstream of the single-cycle CPU.
- Synchronises the two external interrupt lines (intr1, intr2) and detects their rising edges.
- Latches pending requests, applies a mask and fixed priority (intr1 > intr2), and presents one registered request plus handler vector to the CPU.
- Tracks the in-service interrupt through an ack / return-from-interrupt handshake.

Parameters:
- ADDR_W, 10, width of handler vector (CPU program-counter width).
- VEC1, 10'h3F0, handler address for intr1.
- VEC2, 10'h3F8, handler address for intr2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- intr1  input  1  external interrupt 1, asynchronous, rising-edge triggered.
- intr2  input  1  external interrupt 2, asynchronous, rising-edge triggered.
- ack  input  1  CPU accepts the request currently shown on irq/vector (1-cycle pulse).
- reti  input  1  CPU return-from-interrupt (1-cycle pulse).
- mask_we  input  1  write enable for mask register.
- mask_wd  input  2  new mask value; bit0 = intr1, bit1 = intr2; 1 = masked.
- irq  output  1  interrupt request to CPU (registered).
- vector  output  ADDR_W  handler address for the request on irq (registered).
- pending  output  2  latched pending bits {intr2, intr1}.
- in_service  output  2  in-service bits {intr2, intr1}.

Behaviour:
- Reset (reset=0, async): irq=0, vector=0, pending=0, in_service=0, mask=2'b00, synchroniser/edge flops=0, state=IDLE.
- Synchroniser: each intrX passes through 2 flops plus a third flop for edge detection; edge = s2 & ~s3.
- Latency: intrX high before clk edge k -> pending bit set after edge k+2 -> irq/vector valid after edge k+3.
- Pending: set on a detected edge, cleared when granted by ack.
  - Edge and grant of the same source in the same cycle: set wins, pending stays 1.
  - Edges while already pending are merged; no counting.
- Mask: written at the clock edge when mask_we=1.
  - Masking never clears pending; a masked pending bit simply cannot raise irq.
- States:
  - IDLE: irq_next = |(pending & ~mask). When 1, go to REQ.
  - REQ:
    - irq=1; vector = VEC1 if intr1 pending and unmasked, else VEC2. Recomputed every cycle, so a later intr1 overrides a waiting intr2.
    - If all eligible pending bits become masked: irq=0, back to IDLE.
    - ack=1: grant the source currently shown on vector. Clear its pending bit, set its in_service bit, irq=0, go to SVC.
  - SVC:
    - irq held 0; vector holds the granted address.
    - reti=1: clear the in_service bit, go to IDLE. irq may re-rise on the following edge if other work is pending.
- Ignored inputs:
  - ack while irq=0 is ignored.
  - reti outside SVC is ignored.
  - ack and reti together in REQ: ack is processed, reti is ignored.
- Reset mid-operation: all state is lost immediately, including pending requests and in_service.

Optional Feature:
- Macro: INTR_NESTING_EN.
- Defined:
  - While in SVC for intr2, an unmasked pending intr1 raises irq with vector=VEC1.
  - ack grants it and sets in_service[0] (both bits may be 1).
  - The first reti clears the highest-priority in-service bit (intr1). The controller stays in SVC until in_service==0.
  - intr2 never preempts intr1.
- Not defined: no preemption; irq is always 0 in SVC.

Test Plan:
- Reset, intr1 0->1 at edge k, no ack -> pending=2'b01 after k+2; irq=1 and vector=VEC1 after k+3; irq holds until ack.
- intr2 and intr1 rise in the same cycle, then ack -> vector=VEC1; after ack pending=2'b10, in_service=2'b01, irq=0. reti -> irq=1 with vector=VEC2 on the next edge.
- mask_wd=2'b01, intr1 pulse -> pending=2'b01, irq stays 0. Write mask=0 -> irq=1 and vector=VEC1 one cycle later.
- intr2 in REQ (vector=VEC2), intr1 edge arrives before ack -> vector switches to VEC1; ack grants intr1, pending[1] stays 1.
- In SVC, assert reset=0 for 1 ns -> all outputs 0 immediately; later intr2 edge is serviced normally.
- With INTR_NESTING_EN: intr2 acked (SVC), then intr1 edge -> irq=1, vector=VEC1. Ack -> in_service=2'b11. reti -> 2'b10; reti -> 2'b00, state IDLE.
